// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: the W-stage has priority and a buffered secondary writer fills free slots.
// A starving FIFO head raises stall_req, and per-register pending flags feed the hazard unit.
module rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        alt_valid,
    output logic        alt_ready,
    input  logic [4:0]  alt_addr,
    input  logic [31:0] alt_data,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        stall_req,
    input  logic [4:0]  rs_addr,
    output logic        rs_pend,
    input  logic [4:0]  rt_addr,
    output logic        rt_pend,
    input  logic [4:0]  wd_addr,
    output logic        wd_pend
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT, STARVE} state_t;

    state_t           state;
    logic [SW-1:0]    starve_cnt;
    logic [4:0]       addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    fill;
    logic [CW-1:0]    fill_next;
    logic             empty;
    logic             full;
    logic             wb_hit;
    logic             push;
    logic             pop;

    assign empty     = (fill == '0);
    assign full      = (fill == CW'(DEPTH));
    assign wb_hit    = wb_we && (wb_addr != 5'd0);
    assign pop       = !empty && !wb_hit;
    // A full FIFO refuses even when it pops this cycle, keeping alt_ready a pure function of state.
    assign alt_ready = !full;
    assign push      = alt_valid && !full && (alt_addr != 5'd0);
    assign fill_next = fill + CW'(push) - CW'(pop);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (wb_hit) begin
            rf_we   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
        end else if (!empty) begin
            rf_we   = 1'b1;
            rf_addr = addr_mem[rd_ptr];
            rf_data = data_mem[rd_ptr];
        end
    end

    always_comb begin
        rs_pend = 1'b0;
        rt_pend = 1'b0;
        wd_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && addr_mem[i] == rs_addr && rs_addr != 5'd0) rs_pend = 1'b1;
            if (valid[i] && addr_mem[i] == rt_addr && rt_addr != 5'd0) rt_pend = 1'b1;
            if (valid[i] && addr_mem[i] == wd_addr && wd_addr != 5'd0) wd_pend = 1'b1;
        end
    end

    // NOTE: payload storage is deliberately not reset; the reset valid bits and fill count qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= alt_addr;
            data_mem[wr_ptr] <= alt_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every update sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            valid      <= '0;
            state      <= IDLE;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            fill <= fill_next;
            if (push) begin
                wr_ptr         <= wr_ptr + PW'(1);
                valid[wr_ptr]  <= 1'b1;
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + PW'(1);
                valid[rd_ptr]  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    starve_cnt <= '0;
                    if (push) state <= WAIT;
                end
                WAIT: begin
                    if (fill_next == '0) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end else if (pop) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                        state     <= STARVE;
                        stall_req <= 1'b1;
                    end else begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                STARVE: begin
                    if (pop) begin
                        starve_cnt <= '0;
                        stall_req  <= 1'b0;
                        state      <= (fill_next == '0) ? IDLE : WAIT;
                    end
                end
                default: begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                    stall_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: stimulus queues the expected RF writes and a negedge monitor
// pops and compares every write the DUT issues. Inline checks cover ready, stall and pending flags.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        alt_valid;
    logic        alt_ready;
    logic [4:0]  alt_addr;
    logic [31:0] alt_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall_req;
    logic [4:0]  rs_addr;
    logic        rs_pend;
    logic [4:0]  rt_addr;
    logic        rt_pend;
    logic [4:0]  wd_addr;
    logic        wd_pend;

    int n_total = 0;
    int n_pass  = 0;

    logic [36:0] wb_q[$];
    logic [36:0] alt_q[$];

    rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .alt_valid(alt_valid), .alt_ready(alt_ready), .alt_addr(alt_addr), .alt_data(alt_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .stall_req(stall_req),
        .rs_addr(rs_addr), .rs_pend(rs_pend), .rt_addr(rt_addr), .rt_pend(rt_pend),
        .wd_addr(wd_addr), .wd_pend(wd_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad);
        wb_we     = we;
        wb_addr   = wa;
        wb_data   = wd;
        alt_valid = av;
        alt_addr  = aa;
        alt_data  = ad;
        if (we && wa != 5'd0) wb_q.push_back({wa, wd});
    endtask

    // Monitor: a W-stage hit must appear on the port; any other write must be the next buffered entry.
    always @(negedge clk) begin
        logic [36:0] e;
        if (reset) begin
            if (wb_we && wb_addr != 5'd0) begin
                if (wb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL wb_sb_empty: got write %0h:%0h with no expectation", rf_addr, rf_data);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_write", {27'd0, rf_we, rf_addr, rf_data}, {27'd0, 1'b1, e});
                end
            end else if (rf_we) begin
                if (alt_q.size() == 0) begin
                    n_total++;
                    $display("FAIL alt_unexpected: got write %0h:%0h, none expected", rf_addr, rf_data);
                end else begin
                    e = alt_q.pop_front();
                    check("alt_write", {27'd0, rf_addr, rf_data}, {27'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        wd_addr = 5'd0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        sample();
        check("rst_alt_ready", alt_ready, 1);
        check("rst_rf_we",     rf_we,     0);
        check("rst_stall",     stall_req, 0);
        check("rst_pend",      {rs_pend, rt_pend, wd_pend}, 0);
        step();
        reset = 1'b1;

        // 1: single buffered write, written the cycle after the push
        step(); rt_addr = 5'd8;
        drive(0, 0, 0, 1, 8, 32'h0000_FFFF); alt_q.push_back({5'd8, 32'h0000_FFFF});
        sample(); check("t1_ready", alt_ready, 1); check("t1_rt_pend_pre", rt_pend, 0);
        check("t1_no_bypass", rf_we, 0);
        step(); drive(0, 0, 0, 0, 0, 0);
        sample(); check("t1_rf_we", rf_we, 1); check("t1_rt_pend", rt_pend, 1);
        step();
        sample(); check("t1_rf_idle", rf_we, 0); check("t1_rt_pend_post", rt_pend, 0);

        // 2: starvation under a continuously busy W-stage
        step(); wd_addr = 5'd10;
        drive(1, 9, 32'h9000_0000, 1, 10, 32'h0000_0A10); alt_q.push_back({5'd10, 32'h0000_0A10});
        sample();
        for (int c = 1; c <= 5; c++) begin
            step(); drive(1, 9, 32'h9000_0000 + c, 0, 0, 0);
            sample();
            if (c == 1) check("t2_wd_pend", wd_pend, 1);
            if (c == 3) check("t2_stall_early", stall_req, 0);
            if (c == 5) check("t2_stall", stall_req, 1);
        end
        step(); drive(0, 0, 0, 0, 0, 0);
        sample(); check("t2_stall_hold", stall_req, 1); check("t2_drain", rf_we, 1);
        step();
        sample(); check("t2_stall_clear", stall_req, 0); check("t2_wd_pend_clr", wd_pend, 0);

        // 3: overflow with DEPTH=2, then in-order drain
        rs_addr = 5'd1; rt_addr = 5'd2;
        step(); drive(1, 9, 32'h9300_0001, 1, 1, 32'h0000_0001); alt_q.push_back({5'd1, 32'h1});
        sample(); check("t3_ready_a", alt_ready, 1);
        step(); drive(1, 9, 32'h9300_0002, 1, 2, 32'h0000_0002); alt_q.push_back({5'd2, 32'h2});
        sample(); check("t3_ready_b", alt_ready, 1);
        step(); drive(1, 9, 32'h9300_0003, 1, 3, 32'h0000_0003);
        sample(); check("t3_full", alt_ready, 0); check("t3_pend", {rs_pend, rt_pend}, 2'b11);
        step(); drive(0, 0, 0, 0, 0, 0);
        sample(); check("t3_full_pop", alt_ready, 0);
        step();
        sample(); check("t3_pend_mid", {rs_pend, rt_pend}, 2'b01); check("t3_ready_c", alt_ready, 1);
        step();
        sample(); check("t3_empty", rf_we, 0); check("t3_pend_end", {rs_pend, rt_pend}, 2'b00);

        // 4: alt_addr 0 handshakes but is dropped
        wd_addr = 5'd0;
        step(); drive(0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        sample(); check("t4_ready", alt_ready, 1);
        step(); drive(0, 0, 0, 0, 0, 0);
        sample(); check("t4_rf_we", rf_we, 0); check("t4_wd_pend0", wd_pend, 0);
        step();
        sample(); check("t4_rf_we2", rf_we, 0);

        // 5: W-stage write to r0 leaves the slot free for the FIFO head
        step(); drive(1, 9, 32'h9500_0000, 1, 5, 32'h0000_0555); alt_q.push_back({5'd5, 32'h555});
        sample();
        step(); drive(1, 0, 32'h1234_5678, 0, 0, 0);
        sample(); check("t5_r0_slot", rf_we, 1);
        step(); drive(0, 0, 0, 0, 0, 0);
        sample(); check("t5_idle", rf_we, 0);

        // 6: reset in the middle of a drain
        wd_addr = 5'd12;
        step(); drive(1, 9, 32'h9600_0001, 1, 11, 32'h0000_0B11); alt_q.push_back({5'd11, 32'hB11});
        sample();
        step(); drive(1, 9, 32'h9600_0002, 1, 12, 32'h0000_0B12); alt_q.push_back({5'd12, 32'hB12});
        sample(); check("t6_ready", alt_ready, 1);
        step(); drive(0, 0, 0, 0, 0, 0);
        sample(); check("t6_wd_pend", wd_pend, 1); check("t6_full", alt_ready, 0);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_ready", alt_ready, 1);
        check("t6_rst_rf_we", rf_we, 0);
        check("t6_rst_stall", stall_req, 0);
        check("t6_rst_pend", wd_pend, 0);
        alt_q.delete();
        step(); reset = 1'b1;
        step();
        sample(); check("t6_post_rf_we", rf_we, 0);

        check("end_wb_q", wb_q.size(), 0);
        check("end_alt_q", alt_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
